// File: rtl/fpu_norm_stage.sv
// fpu_norm_stage: classifies one unpacked single-precision operand, inserts the
// hidden bit, removes the exponent bias and left-normalises denormals one bit
// per cycle before handing the result to the arithmetic core.
// Latency: 1 cycle for normal/zero/inf/NaN, 1+k cycles for a denormal needing
// k shifts. Backpressure: one operand in flight; in_ready only in IDLE, and the
// result is held stable in DONE until out_ready.
//
// Optional feature: define FPU_NORM_FTZ_EN to flush denormal inputs to zero
// (class 01, latency 1, NORM never entered).
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   in_valid/in_ready          operand handshake
//   in_sign, in_man, in_exp    sign, {frac,3'b000} mantissa, zero-extended biased exp
//   out_valid/out_ready        result handshake
//   out_sign, out_man, out_exp sign, normalised mantissa (hidden bit 26), unbiased exp
//   out_class                  00 finite, 01 zero, 10 infinity, 11 NaN
module fpu_norm_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [26:0] in_man,
  input  logic [9:0]  in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [26:0] out_man,
  output logic [9:0]  out_exp,
  output logic [1:0]  out_class
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]  CLS_FIN  = 2'b00;
  localparam logic [1:0]  CLS_ZERO = 2'b01;
  localparam logic [1:0]  CLS_INF  = 2'b10;
  localparam logic [1:0]  CLS_NAN  = 2'b11;
  localparam logic [9:0]  EXP_SPEC = 10'h080;  // +128 for inf/NaN
  localparam logic [9:0]  EXP_DEN  = 10'h382;  // -126 for zero/denormal
  localparam logic [9:0]  BIAS     = 10'd127;
  localparam logic [26:0] HIDDEN   = 27'h4000000;

  state_t      state, state_d;
  logic        sign_q, sign_d;
  logic [26:0] man_q, man_d;
  logic [9:0]  exp_q, exp_d;
  logic [1:0]  cls_q, cls_d;

  logic [7:0]  e8;
  logic        man_zero;
  logic        accept;

  assign e8       = in_exp[7:0];
  assign man_zero = (in_man == 27'd0);
  assign accept   = in_valid && (state == IDLE);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sign  = sign_q;
  assign out_man   = man_q;
  assign out_exp   = exp_q;
  assign out_class = cls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      man_q  <= 27'd0;
      exp_q  <= 10'd0;
      cls_q  <= CLS_FIN;
    end else begin
      sign_q <= sign_d;
      man_q  <= man_d;
      exp_q  <= exp_d;
      cls_q  <= cls_d;
    end
  end

  always_comb begin
    state_d = state;
    sign_d  = sign_q;
    man_d   = man_q;
    exp_d   = exp_q;
    cls_d   = cls_q;

    unique case (state)
      IDLE: begin
        if (accept) begin
          sign_d  = in_sign;
          state_d = DONE;
          if (e8 == 8'hFF) begin
            cls_d = man_zero ? CLS_INF : CLS_NAN;
            man_d = in_man;
            exp_d = EXP_SPEC;
          end else if (e8 == 8'h00) begin
            exp_d = EXP_DEN;
            if (man_zero) begin
              cls_d = CLS_ZERO;
              man_d = 27'd0;
            end else begin
`ifdef FPU_NORM_FTZ_EN
              cls_d = CLS_ZERO;
              man_d = 27'd0;
`else
              cls_d   = CLS_FIN;
              man_d   = in_man;
              state_d = NORM;
`endif
            end
          end else begin
            cls_d = CLS_FIN;
            man_d = in_man | HIDDEN;
            exp_d = in_exp - BIAS;
          end
        end
      end

      NORM: begin
        // Input bit 26 is always 0, so NORM is entered with at least one
        // shift pending. Leave as soon as the shift lands a 1 in bit 26 so
        // a k-shift denormal is presented k+1 cycles after accept.
        if (!man_q[26]) begin
          man_d = {man_q[25:0], 1'b0};
          exp_d = exp_q - 10'd1;
          if (man_q[25]) begin
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fpu_norm_stage.sv
module tb_fpu_norm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [26:0] in_man;
  logic [9:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [26:0] out_man;
  logic [9:0]  out_exp;
  logic [1:0]  out_class;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_norm_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_man    (in_man),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_man   (out_man),
    .out_exp   (out_exp),
    .out_class (out_class)
  );

  typedef struct {
    logic [1:0]  cls;
    logic [26:0] man;
    logic [9:0]  exp;
    int          lat;
  } res_t;

  // Reference: value-level view of the operand, latency = 1 + number of shifts.
  function automatic res_t model(input logic [26:0] m, input logic [9:0] e);
    res_t r;
    int   e8;
    int   p;
    int   k;
    e8 = int'(e[7:0]);
    r.lat = 1;
    if (e8 == 255) begin
      r.cls = (m == 0) ? 2'b10 : 2'b11;
      r.man = m;
      r.exp = 10'(128);
    end else if (e8 == 0) begin
      r.exp = 10'(-126);
      if (m == 0) begin
        r.cls = 2'b01;
        r.man = 27'd0;
      end else begin
`ifdef FPU_NORM_FTZ_EN
        r.cls = 2'b01;
        r.man = 27'd0;
`else
        p = 0;
        for (int i = 0; i < 27; i++) if (m[i]) p = i;
        k = 26 - p;
        r.cls = 2'b00;
        r.man = m << k;
        r.exp = 10'(-126 - k);
        r.lat = 1 + k;
`endif
      end
    end else begin
      r.cls = 2'b00;
      r.man = m + 27'(1 << 26);
      r.exp = 10'(e8 - 127);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one operand; hold = cycles of out_ready=0 after out_valid rises.
  task automatic run_op(input logic s, input logic [9:0] e, input logic [26:0] m,
                        input int hold);
    res_t        r;
    int          n;
    logic [26:0] man_c;
    logic [9:0]  exp_c;
    logic [1:0]  cls_c;
    logic        sgn_c;
    r = model(m, e);
    @(negedge clk);
    chk("in_ready_before", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_man    = m;
    @(negedge clk);  // cycle T+1
    in_valid = 1'b0;
    in_man   = 27'(($urandom));
    in_exp   = 10'($urandom);
    in_sign  = 1'($urandom);
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(r.lat));
    chk("out_sign", 32'(out_sign), 32'(s));
    chk("out_man", 32'(out_man), 32'(r.man));
    chk("out_exp", 32'(out_exp), 32'(r.exp));
    chk("out_class", 32'(out_class), 32'(r.cls));
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      sgn_c = out_sign; man_c = out_man; exp_c = out_exp; cls_c = out_class;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_stable", {out_sign, out_class, out_exp, 19'd0} ^ 32'(out_man),
            {sgn_c, cls_c, exp_c, 19'd0} ^ 32'(man_c));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_man    = 27'd0;
    in_exp    = 10'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sign", 32'(out_sign), 32'd0);
    chk("rst_man", 32'(out_man), 32'd0);
    chk("rst_exp", 32'(out_exp), 32'd0);
    chk("rst_class", 32'(out_class), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Directed cases
    run_op(1'b0, 10'h07F, 27'h0000000, 0);  // 1.0f
    run_op(1'b0, 10'h000, 27'h0000008, 0);  // smallest denormal
    run_op(1'b1, 10'h000, 27'h2000000, 0);  // largest denormal
    run_op(1'b0, 10'h0FF, 27'h0000000, 0);  // inf
    run_op(1'b1, 10'h0FF, 27'h0000008, 0);  // NaN
    run_op(1'b1, 10'h000, 27'h0000000, 0);  // -0
    run_op(1'b0, 10'h0FE, 27'h3FFFFF8, 0);  // max finite
    run_op(1'b0, 10'h001, 27'h0000000, 0);  // min normal
    run_op(1'b0, 10'h000, 27'h0000008, 5);  // backpressure on denormal
    run_op(1'b1, 10'h080, 27'h1234568, 5);  // backpressure on normal

    // Reset in the 10th NORM cycle of the smallest denormal
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 10'h000; in_man = 27'h0000008;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_outs", {31'd0, out_sign} | 32'(out_man) | 32'(out_exp) | 32'(out_class), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    run_op(1'b0, 10'h07F, 27'h0000000, 0);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      logic [9:0]  e;
      logic [26:0] m;
      int          kind;
      kind = int'($urandom_range(0, 4));
      m = {1'b0, 23'($urandom), 3'b000};
      if ($urandom_range(0, 5) == 0) m = 27'd0;
      case (kind)
        0, 1: e = 10'h000;
        2:    e = 10'h0FF;
        default: e = 10'($urandom_range(1, 254));
      endcase
      run_op(1'($urandom), e, m, int'($urandom_range(0, 1)) * int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_norm_stage.md
# fpu_norm_stage

Second stage of the FPU operand front end. Consumes one unpacked single-precision operand: sign, 27-bit mantissa field with 3 guard bits (`{frac[22:0],3'b000}`) and 10-bit zero-extended biased exponent. Classifies the operand, inserts the hidden bit, removes the bias, and left-normalises denormals one bit per cycle. Results go to the arithmetic core over a valid/ready handshake.

## Interface
- No parameters. Field widths are fixed at 27-bit mantissa and 10-bit exponent.
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand present
- `in_ready`  out  1  stage can accept an operand
- `in_sign`  in  1  operand sign
- `in_man`  in  27  `{frac[22:0],3'b000}`; bit 26 is always 0 on input
- `in_exp`  in  10  `{2'b00, biased_exp[7:0]}`
- `out_valid`  out  1  normalised result present
- `out_ready`  in  1  consumer accepts result
- `out_sign`  out  1  sign, passed through
- `out_man`  out  27  normalised mantissa; hidden bit at bit 26
- `out_exp`  out  10  unbiased exponent, two's complement
- `out_class`  out  2  00 finite, 01 zero, 10 infinity, 11 NaN

## Operation
- FSM states: IDLE, NORM, DONE. Reset enters IDLE.
- `in_ready` = (state == IDLE). This is combinational from state; there is no same-cycle bypass from DONE.
- **Accept.** An operand is accepted on a cycle with `in_valid && in_ready`. On that edge the stage registers sign/man/exp and classifies with `e8 = in_exp[7:0]` and `m = in_man`:
  - `e8 == 255`, `m == 0`: class 10. Man passes through, exp = 128 (0x080). Next state DONE.
  - `e8 == 255`, `m != 0`: class 11. Man passes through unchanged, exp = 128. Next state DONE.
  - `e8 == 0`, `m == 0`: class 01. Man = 0, exp = -126 (0x382). Next state DONE.
  - `e8 == 0`, `m != 0` (denormal): class 00. Man = m, exp = -126 (0x382). Next state NORM.
  - Otherwise: class 00. Man = `m | 27'h4000000`, exp = `in_exp - 127` mod 2^10. Next state DONE.
- **NORM.** Each cycle: if `man[26] == 0`, then `man <= man << 1` and `exp <= exp - 1`. Once `man[26] == 1`, go to DONE.
  - A denormal needs at most 23 shifts. The smallest denormal reaches exp -149 (0x36B). The 10-bit signed exponent never wraps.
- **DONE.** `out_valid = 1`. When `out_ready` is high, the result is consumed and the next state is IDLE.
  - `out_*` must hold stable while `out_valid && !out_ready`.
- The sign is never modified, including for zero and NaN.
- Reset mid-NORM or mid-DONE abandons the operand. The in-flight result is never presented.

## Timing
- Reset values: `out_valid = 0`, `out_sign = 0`, `out_man = 0`, `out_exp = 0`, `out_class = 00`. State is IDLE, so `in_ready = 1`.
- Latency is measured from the accept edge T:
  - Normal, zero, inf and NaN operands: `out_valid` is high in cycle T+1.
  - Denormal needing k shifts (1 ≤ k ≤ 23): `out_valid` is high in cycle T+1+k.
- With `out_ready` held high, throughput is one normal operand every 2 cycles: the accept cycle plus the DONE cycle.
- `in_ready` falls in the cycle after accept and rises in the cycle after the DONE handshake.

## Configuration
- `FPU_NORM_FTZ_EN`
  - Defined: denormal inputs flush to zero. Class 01, man = 0, exp = 0x382, sign kept, latency 1. The NORM state is unreachable.
  - Undefined: denormals are normalised as described in Operation.

## Test plan
- 1.0f (`in_exp = 0x07F`, `in_man = 0`) -> `out_exp = 0x000`, `out_man = 0x4000000`, class 00, `out_valid` at T+1.
- Smallest denormal (`in_exp = 0`, `in_man = 0x0000008`) -> 23 shifts, `out_exp = 0x36B`, `out_man = 0x4000000`, `out_valid` at T+24. With `FPU_NORM_FTZ_EN` defined -> class 01, `out_man = 0`, `out_valid` at T+1.
- Largest denormal (`in_exp = 0`, `in_man = 0x2000000`) -> `out_exp = 0x381`, `out_man = 0x4000000`, `out_valid` at T+2.
- Specials:
  - `in_exp = 0x0FF`, `in_man = 0` -> class 10.
  - `in_exp = 0x0FF`, `in_man = 0x0000008` -> class 11, `out_man = 0x0000008`.
  - `in_sign = 1`, `in_exp = 0`, `in_man = 0` -> class 01, `out_sign = 1`.
- Backpressure: hold `out_ready = 0` for 5 cycles after `out_valid` rises -> `out_*` stable and `in_ready = 0` throughout. On the cycle after `out_ready = 1`, `in_ready = 1`.
- Assert `rst` at the 10th NORM cycle of the smallest denormal -> `out_valid` stays 0 and all outputs are 0. After release, `in_ready = 1` and a following 1.0f completes normally.
